// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement adder/subtractor. Adds CHUNK bits per clock,
// rippling the carry between chunks through a register, with valid/ready
// handshakes on both sides and carry/borrow, overflow and zero flags.
module seq_add_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             car_bor,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Operands and result are viewed as arrays of chunks so the counter indexes them directly.
    typedef logic [NCH-1:0][CHUNK-1:0] word_t;

    state_e           state_q, state_d;
    word_t            a_q, a_d;
    word_t            b_q, b_d;
    word_t            sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             car_bor_q, car_bor_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [CHUNK:0]   chunk_sum;

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign car_bor   = car_bor_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Chunk adder: current chunk of both operands plus the rippled carry.
    always_comb begin
        chunk_sum = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and datapath updates for the accept / run / deliver sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        car_bor_d = car_bor_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    // Subtract as A + ~B + 1: invert B here, inject the +1 as the first carry.
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[cnt_q] = chunk_sum[CHUNK-1:0];
                carry_d      = chunk_sum[CHUNK];
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    car_bor_d = chunk_sum[CHUNK];
                    ovf_d     = (a_q[NCH-1][CHUNK-1] == b_q[NCH-1][CHUNK-1]) &&
                                (sum_d[NCH-1][CHUNK-1] != a_q[NCH-1][CHUNK-1]);
                    zero_d    = (sum_d == '0);
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            car_bor_q <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            car_bor_q <= car_bor_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: a vector table run through the chunked
// (CHUNK=4) instance, one single-chunk (CHUNK=16) case, plus hand-written
// backpressure and mid-operation reset sequences.
module tb_seq_add_sub;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_drv, out_ready_drv, sel;
    logic [WIDTH-1:0] a, b;
    logic             sub;

    logic             iv1, or1, ir1, ov1, cb1, ovf1, z1;
    logic             iv2, or2, ir2, ov2, cb2, ovf2, z2;
    logic [WIDTH-1:0] s1, s2;

    logic             cur_ir, cur_ov, cur_cb, cur_ovf, cur_z;
    logic [WIDTH-1:0] cur_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // sel steers the handshakes to one instance; the other stays idle.
    assign iv1 = in_valid_drv & ~sel;
    assign iv2 = in_valid_drv & sel;
    assign or1 = out_ready_drv & ~sel;
    assign or2 = out_ready_drv & sel;
    assign cur_ir  = sel ? ir2  : ir1;
    assign cur_ov  = sel ? ov2  : ov1;
    assign cur_s   = sel ? s2   : s1;
    assign cur_cb  = sel ? cb2  : cb1;
    assign cur_ovf = sel ? ovf2 : ovf1;
    assign cur_z   = sel ? z2   : z1;

    seq_add_sub #(.WIDTH(WIDTH), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .sub(sub),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .car_bor(cb1), .ovf(ovf1), .zero(z1)
    );

    seq_add_sub #(.WIDTH(WIDTH), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b), .sub(sub),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .car_bor(cb2), .ovf(ovf2), .zero(z2)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cb;
        logic             exp_ovf;
        logic             exp_zero;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation, measure latency, check result, complete the handshake.
    task automatic run_op(input vec_t v, input int exp_lat, input string tag);
        int lat;
        check({tag, " in_ready before accept"}, 32'(cur_ir), 32'd1);
        a = v.a;
        b = v.b;
        sub = v.sub;
        in_valid_drv = 1'b1;
        tick();
        in_valid_drv = 1'b0;
        a = 'x;
        b = 'x;
        sub = 1'bx;
        lat = 0;
        while (!cur_ov && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sum"}, 32'(cur_s), 32'(v.exp_sum));
        check({tag, " car_bor"}, 32'(cur_cb), 32'(v.exp_cb));
        check({tag, " ovf"}, 32'(cur_ovf), 32'(v.exp_ovf));
        check({tag, " zero"}, 32'(cur_z), 32'(v.exp_zero));
        out_ready_drv = 1'b1;
        tick();
        out_ready_drv = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(cur_ov), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(cur_ir), 32'd1);
    endtask

    vec_t vecs[10];
    vec_t v;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        in_valid_drv = 1'b0;
        out_ready_drv = 1'b0;
        sel = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        tick();
        tick();
        check("reset in_ready low during rst", 32'(ir1), 32'd0);
        check("reset out_valid", 32'(ov1), 32'd0);
        check("reset sum", 32'(s1), 32'd0);
        check("reset flags", {29'd0, cb1, ovf1, z1}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset in_ready after release", 32'(ir1), 32'd1);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 4, $sformatf("vec%0d", i));
        end

        // Single-chunk instance: one RUN cycle, same result.
        sel = 1'b1;
        #1;
        run_op(vecs[6], 1, "chunk16 sub equal");
        sel = 1'b0;
        #1;

        // Backpressure: hold DONE while new requests are offered.
        a = 16'h1234;
        b = 16'h4321;
        sub = 1'b0;
        in_valid_drv = 1'b1;
        tick();
        in_valid_drv = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp out_valid", 32'(ov1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a = 16'hFFFF;
            b = 16'h0F0F;
            sub = 1'b1;
            in_valid_drv = 1'(i % 2 == 0);
            tick();
            check("bp hold out_valid", 32'(ov1), 32'd1);
            check("bp hold in_ready", 32'(ir1), 32'd0);
            check("bp hold sum", 32'(s1), 32'h5555);
            check("bp hold flags", {29'd0, cb1, ovf1, z1}, 32'd0);
        end
        in_valid_drv = 1'b0;
        out_ready_drv = 1'b1;
        tick();
        out_ready_drv = 1'b0;
        check("bp release in_ready", 32'(ir1), 32'd1);
        check("bp release out_valid", 32'(ov1), 32'd0);
        check("bp release sum kept", 32'(s1), 32'h5555);

        // Reset on the 2nd RUN cycle aborts the operation.
        a = 16'h0F0F;
        b = 16'h0101;
        sub = 1'b0;
        in_valid_drv = 1'b1;
        tick();
        in_valid_drv = 1'b0;
        tick();
        rst = 1'b1;
        out_ready_drv = 1'b1;
        tick();
        out_ready_drv = 1'b0;
        check("rst mid-run out_valid", 32'(ov1), 32'd0);
        check("rst mid-run sum", 32'(s1), 32'd0);
        check("rst mid-run flags", {29'd0, cb1, ovf1, z1}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst mid-run in_ready after release", 32'(ir1), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst aborted op stays silent", 32'(ov1), 32'd0);
        end
        v = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        run_op(v, 4, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
Multi-cycle, parametrised two's-complement adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register. Add or subtract is selected per operation. Inputs and outputs use valid/ready handshakes, and the block reports carry/borrow, signed overflow and zero flags. It serves as the wide arithmetic datapath element where a full-width combinational ripple chain would not meet timing.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 2.
CHUNK, 4, bits added per clock; WIDTH must be a multiple of CHUNK (elaboration error otherwise); CHUNK == WIDTH is legal.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
car_bor  output  1  raw carry out of A + (B xor {sub}) + sub; for subtract, 1 = no borrow, 0 = borrow
ovf  output  1  signed two's-complement overflow
zero  output  1  sum == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Constants: NCH = WIDTH/CHUNK. Chunk index counter is clog2(NCH) bits, minimum 1.
- States: IDLE, RUN, DONE.
- Reset: state = IDLE; sum = 0, car_bor = 0, ovf = 0, zero = 0, out_valid = 0; internal operand, carry and counter registers = 0.
- in_ready = (state == IDLE) && !rst. out_valid = (state == DONE).
- IDLE:
  - When in_valid && in_ready at an edge, latch a_r = a and b_r = b xor {WIDTH{sub}}.
  - Set the carry register to sub and the counter to 0; go to RUN.
  - Operand inputs are don't-care after the accept edge.
- RUN, each cycle:
  - Add chunk k of a_r, chunk k of b_r, and the carry register.
  - Write the CHUNK-bit result into sum[k*CHUNK +: CHUNK] and the carry out into the carry register; increment k.
  - On the edge that processes chunk NCH-1:
    - car_bor = final carry.
    - ovf = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]), using b_r after inversion.
    - zero = (full result == 0), evaluated on the completed word including the chunk being written.
    - Go to DONE.
- Latency: out_valid rises exactly NCH cycles after the accept edge. With CHUNK == WIDTH, RUN lasts 1 cycle.
- During RUN, sum is partially updated and is not valid; flags hold their previous values until the final chunk.
- DONE:
  - sum, car_bor, ovf and zero are held stable while out_valid = 1 and out_ready = 0. Backpressure is unbounded.
  - When out_ready = 1 at an edge, go to IDLE. Outputs keep their values but out_valid drops.
- in_valid while not in IDLE is ignored: no queueing, no error.
- Throughput: one operation per NCH+2 cycles minimum (accept, NCH RUN cycles, DONE handshake, back to IDLE).
- Simultaneous rst with any handshake: rst wins. The operation is aborted and nothing is accepted or delivered.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with the reset values above. in_ready = 1 on the first cycle after rst deasserts.
- Arithmetic is unsigned-modular. Operand interpretation (signed vs unsigned) is the consumer's choice via car_bor and ovf.

Test Plan:
1. WIDTH=16, CHUNK=4. Add 0x1234 + 0x4321 -> sum 0x5555, car_bor 0, ovf 0, zero 0; out_valid exactly 4 cycles after accept.
2. Subtract 0x0005 - 0x0007 -> 0xFFFE, car_bor 0 (borrow), ovf 0. Then 0x0007 - 0x0005 -> 0x0002, car_bor 1.
3. Overflow cases:
   - Add 0x7FFF + 0x0001 -> 0x8000, ovf 1, car_bor 0.
   - Subtract 0x8000 - 0x0001 -> 0x7FFF, ovf 1, car_bor 1.
   - Add 0xFFFF + 0x0001 -> 0x0000, car_bor 1, ovf 0, zero 1.
4. Subtract 0x1234 - 0x1234 -> sum 0, zero 1, car_bor 1, ovf 0. Repeat with CHUNK=16 -> out_valid 1 cycle after accept, same result.
5. Backpressure: hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with new operands. Required: sum/flags constant, in_ready 0, new request ignored. After out_ready = 1, in_ready = 1 on the next cycle.
6. Assert rst on the 2nd RUN cycle. Required: out_valid never asserts, all outputs 0, in_ready 1 after release. A following 0x00FF + 0x0001 then yields 0x0100.
